// File: rtl/trng_conditioner_if.sv
// trng_conditioner_if
// Groups the raw-sample input stream and the conditioned-word output stream
// of the TRNG conditioner.
//   raw_bit, raw_valid   : raw samples from the ring-oscillator sampler
//   word_out, word_valid : FIFO head word and its valid flag (first-word fall-through)
//   word_pop             : consume the head word
//   fifo_level           : number of buffered words
// The conditioner uses the master modport; the word consumer (register
// wrapper or bench) uses the slave modport. FIFO_DEPTH must match the
// conditioner instance so that fifo_level has the right width.
interface trng_conditioner_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               raw_bit;
  logic               raw_valid;
  logic [31:0]        word_out;
  logic               word_valid;
  logic               word_pop;
  logic [LEVEL_W-1:0] fifo_level;

  modport master (
    input  raw_bit,
    input  raw_valid,
    input  word_pop,
    output word_out,
    output word_valid,
    output fifo_level
  );

  modport slave (
    output raw_bit,
    output raw_valid,
    output word_pop,
    input  word_out,
    input  word_valid,
    input  fifo_level
  );
endinterface

// File: rtl/trng_conditioner.sv
// trng_conditioner
// Post-processing between the ring-oscillator sampler and the AXI-Lite
// register wrapper. Raw bits run through a repetition-count test and an
// adaptive-proportion test, are debiased by a von Neumann corrector, packed
// MSB-first into 32-bit words and buffered in a small word FIFO.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   enable         : when low, raw samples are ignored and the pair register clears
//   clear          : single-cycle pulse with the same effect as rst
//   bus            : raw sample input, FIFO head output, pop and level
//   rct_alarm      : sticky repetition-count failure
//   apt_alarm      : sticky adaptive-proportion failure
//   words_dropped  : saturating count of completed words lost to a full FIFO
module trng_conditioner #(
  parameter int FIFO_DEPTH = 8,
  parameter int RCT_CUTOFF = 32,
  parameter int APT_WINDOW = 1024,
  parameter int APT_CUTOFF = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  trng_conditioner_if.master       bus,
  output logic                     rct_alarm,
  output logic                     apt_alarm,
  output logic [15:0]              words_dropped
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;
  localparam int RUN_W   = $clog2(RCT_CUTOFF + 1);
  localparam int WIN_W   = $clog2(APT_WINDOW);
  localparam int MATCH_W = $clog2(APT_WINDOW + 1);

  localparam logic [RUN_W-1:0]   RCT_MAX    = RUN_W'(RCT_CUTOFF);
  localparam logic [MATCH_W-1:0] APT_MAX    = MATCH_W'(APT_CUTOFF);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);

  typedef enum logic {
    VN_EMPTY,
    VN_HELD
  } vn_state_t;

  logic               accepted;

  logic               last_bit;
  logic               have_last;
  logic [RUN_W-1:0]   run_cnt;
  logic [RUN_W-1:0]   run_next;
  logic               rct_hit;

  logic [WIN_W-1:0]   win_cnt;
  logic               apt_ref;
  logic [MATCH_W-1:0] match_cnt;
  logic [MATCH_W-1:0] match_next;
  logic               apt_hit;

  logic               alarm_active;
  logic               alarm_flush;
  logic               assemble_ok;

  vn_state_t          vn_state;
  vn_state_t          vn_next;
  logic               held_bit;
  logic               held_next;
  logic               vn_emit;

  logic [31:0]        shift_reg;
  logic [4:0]         bit_cnt;
  logic               word_done;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [LEVEL_W-1:0] level;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               fifo_write;

  // A raw sample only counts when the block is enabled and not being reset
  // or cleared in the same cycle.
  assign accepted = bus.raw_valid & enable & ~rst & ~clear;

  // Repetition-count test: the run restarts at 1 on a changed bit or on the
  // very first bit after reset, and otherwise grows until it saturates at
  // the cutoff. Saturation keeps the counter from wrapping during a stuck
  // source; the alarm is sticky anyway.
  always_comb begin
    run_next = run_cnt;
    if (!have_last || (bus.raw_bit != last_bit)) begin
      run_next = RUN_W'(1);
    end else if (run_cnt != RCT_MAX) begin
      run_next = run_cnt + RUN_W'(1);
    end
  end

  assign rct_hit = accepted & (run_next == RCT_MAX);

  // Adaptive-proportion test: the first bit of every window becomes the
  // reference and counts as the first match. The window counter wraps
  // naturally because the window length is a power of two.
  always_comb begin
    match_next = match_cnt;
    if (win_cnt == '0) begin
      match_next = MATCH_W'(1);
    end else if (bus.raw_bit == apt_ref) begin
      match_next = match_cnt + MATCH_W'(1);
    end
  end

  assign apt_hit = accepted & (match_next == APT_MAX);

  // alarm_flush marks the edge on which a health test trips; the FIFO and
  // the partial word are discarded on that edge. No corrected bits are
  // produced while an alarm is active or being raised.
  assign alarm_active = rct_alarm | apt_alarm;
  assign alarm_flush  = rct_hit | apt_hit;
  assign assemble_ok  = accepted & ~alarm_active & ~alarm_flush;

  // Health-test state. Counters keep running under an alarm so the tests
  // stay continuous; only rst or clear removes an alarm.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      last_bit  <= 1'b0;
      have_last <= 1'b0;
      run_cnt   <= '0;
      win_cnt   <= '0;
      apt_ref   <= 1'b0;
      match_cnt <= '0;
      rct_alarm <= 1'b0;
      apt_alarm <= 1'b0;
    end else if (accepted) begin
      last_bit  <= bus.raw_bit;
      have_last <= 1'b1;
      run_cnt   <= run_next;
      win_cnt   <= win_cnt + WIN_W'(1);
      match_cnt <= match_next;
      if (win_cnt == '0) begin
        apt_ref <= bus.raw_bit;
      end
      if (rct_hit) begin
        rct_alarm <= 1'b1;
      end
      if (apt_hit) begin
        apt_alarm <= 1'b1;
      end
    end
  end

  // Von Neumann corrector state register.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vn_state <= VN_EMPTY;
      held_bit <= 1'b0;
    end else begin
      vn_state <= vn_next;
      held_bit <= held_next;
    end
  end

  // Von Neumann next state: the second bit of a pair emits the held bit
  // when the two differ (10 -> 1, 01 -> 0). Disabling the block or an
  // alarm drops any half pair so pairs realign on the next accepted bit.
  always_comb begin
    vn_next   = vn_state;
    held_next = held_bit;
    vn_emit   = 1'b0;
    if (!enable || alarm_active || alarm_flush) begin
      vn_next = VN_EMPTY;
    end else if (assemble_ok) begin
      case (vn_state)
        VN_EMPTY: begin
          vn_next   = VN_HELD;
          held_next = bus.raw_bit;
        end
        VN_HELD: begin
          vn_next = VN_EMPTY;
          vn_emit = (held_bit != bus.raw_bit);
        end
        default: begin
          vn_next = VN_EMPTY;
        end
      endcase
    end
  end

  // Word assembler: the first corrected bit ends up as the MSB. word_done
  // pulses for one cycle after the 32nd bit; shift_reg still holds the full
  // word on the following edge because the next emission needs a complete
  // pair, i.e. at least two more accepted bits.
  always_ff @(posedge clk) begin
    if (rst || clear || alarm_flush) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (vn_emit) begin
        shift_reg <= {shift_reg[30:0], held_bit};
        bit_cnt   <= bit_cnt + 5'd1;
        if (bit_cnt == 5'd31) begin
          word_done <= 1'b1;
        end
      end
    end
  end

  // FIFO control. A pop frees the head slot in the same cycle, so a push
  // into a full FIFO still succeeds when it coincides with a pop.
  assign fifo_full  = (level == FULL_LEVEL);
  assign fifo_empty = (level == '0);
  assign push       = word_done & ~alarm_active;
  assign pop        = bus.word_pop & bus.word_valid;
  assign fifo_write = push & (~fifo_full | pop) & ~rst & ~clear & ~alarm_flush;

  // Word storage; the pointers and level define what is valid, so the
  // array itself needs no reset.
  always_ff @(posedge clk) begin
    if (fifo_write) begin
      mem[wr_ptr] <= shift_reg;
    end
  end

  // Pointers, level and drop counter. An alarm empties the FIFO but keeps
  // the drop count, which only rst or clear resets.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      level         <= '0;
      words_dropped <= '0;
    end else if (alarm_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (fifo_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && fifo_full && !pop && (words_dropped != 16'hFFFF)) begin
        words_dropped <= words_dropped + 16'd1;
      end
      case ({fifo_write, pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // First-word fall-through head; an empty FIFO reads as zero.
  assign bus.word_out   = fifo_empty ? 32'h0 : mem[rd_ptr];
  assign bus.word_valid = ~fifo_empty & ~alarm_active;
  assign bus.fifo_level = level;

endmodule
